// File: rtl/huffman_mcu_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_mcu_arbiter_if
//  Description : Bundles the three per-component code-word sources and the
//                merged output stream of the MCU arbiter.
//                  src_valid/src_ready/src_last [0]=Y [1]=Cb [2]=Cr
//                  src_data  source i at [i*DATA_W +: DATA_W]
//                  out_valid/out_ready/out_data/out_comp/out_last/out_eof
//                modport slave  : arbiter side (consumes sources, drives out)
//                modport master : environment side (drives sources, sinks out)
//  Revision    : 1.0  initial release
// ============================================================================
interface huffman_mcu_arbiter_if #(
  parameter int DATA_W = 32
);
  logic [2:0]          src_valid;
  logic [2:0]          src_ready;
  logic [3*DATA_W-1:0] src_data;
  logic [2:0]          src_last;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          out_comp;
  logic                out_last;
  logic                out_eof;

  modport slave (
    input  src_valid, src_data, src_last, out_ready,
    output src_ready, out_valid, out_data, out_comp, out_last, out_eof
  );

  modport master (
    output src_valid, src_data, src_last, out_ready,
    input  src_ready, out_valid, out_data, out_comp, out_last, out_eof
  );
endinterface
`default_nettype wire

// File: rtl/huffman_mcu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_mcu_arbiter
//  Description : Merges Y/Cb/Cr Huffman code-word streams into MCU interleave
//                order (Y_PER_MCU Y blocks, C_PER_MCU Cb, C_PER_MCU Cr),
//                back-pressures the non-granted coders and tags the last
//                beat of the frame.
//  Ports       : clk, rst_n      clock, async active-low reset
//                start           frame-start pulse (honoured in IDLE only)
//                mcu_total       MCUs per frame, captured on accepted start
//                bus (slave)     source handshakes and registered output
//                busy            accepted start .. done
//                done            one-cycle pulse once the eof beat has left
//  Revision    : 1.0  initial release
// ============================================================================
module huffman_mcu_arbiter #(
  parameter int DATA_W    = 32,
  parameter int Y_PER_MCU = 4,
  parameter int C_PER_MCU = 1,
  parameter int MCU_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MCU_CNT_W-1:0] mcu_total,
  huffman_mcu_arbiter_if.slave bus,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_Y     = 3'd1,
    ST_CB    = 3'd2,
    ST_CR    = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  localparam logic [2:0] c_y_blks = 3'(Y_PER_MCU);
  localparam logic [2:0] c_c_blks = 3'(C_PER_MCU);
  localparam bit         c_gray   = (C_PER_MCU == 0);

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_blk_cnt, w_blk_cnt_nxt;
  logic [MCU_CNT_W-1:0]  r_mcu_cnt, w_mcu_cnt_nxt;
  logic [MCU_CNT_W-1:0]  r_mcu_total;
  logic [MCU_CNT_W-1:0]  w_mcu_inc;
  logic                  r_out_valid;
  logic [DATA_W-1:0]     r_out_data;
  logic [1:0]            r_out_comp;
  logic                  r_out_last;
  logic                  r_out_eof;
  logic                  r_busy;
  logic                  r_done;

  logic [2:0]            w_grant;
  logic [2:0]            w_src_ready;
  logic [1:0]            w_comp;
  logic [2:0]            w_blk_lim;
  logic                  w_can_load;
  logic                  w_xfer;
  logic [DATA_W-1:0]     w_sel_data;
  logic                  w_sel_last;
  logic                  w_mcu_done;
  logic                  w_eof;
  logic                  w_start_acc;
  logic                  w_done_nxt;

  assign w_mcu_inc = r_mcu_cnt + MCU_CNT_W'(1);

  // Next-state, grant and handshake decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_blk_cnt_nxt = r_blk_cnt;
    w_mcu_cnt_nxt = r_mcu_cnt;
    w_grant       = 3'b000;
    w_comp        = 2'd0;
    w_blk_lim     = c_y_blks;
    w_mcu_done    = 1'b0;
    w_eof         = 1'b0;
    w_start_acc   = 1'b0;
    w_done_nxt    = 1'b0;

    // The output register can take a beat when empty or being drained.
    w_can_load = !r_out_valid || bus.out_ready;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_start_acc   = 1'b1;
          w_blk_cnt_nxt = 3'd0;
          w_mcu_cnt_nxt = '0;
          w_state_nxt   = (mcu_total == '0) ? ST_DRAIN : ST_Y;
        end
      end
      ST_Y: begin
        w_grant   = 3'b001;
        w_comp    = 2'd0;
        w_blk_lim = c_y_blks;
      end
      ST_CB: begin
        w_grant   = 3'b010;
        w_comp    = 2'd1;
        w_blk_lim = c_c_blks;
      end
      ST_CR: begin
        w_grant   = 3'b100;
        w_comp    = 2'd2;
        w_blk_lim = c_c_blks;
      end
      ST_DRAIN: begin
        // Wait until the eof beat has been taken downstream.
        if (!r_out_valid) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_src_ready = w_can_load ? w_grant : 3'b000;
    w_xfer      = |(bus.src_valid & w_src_ready);

    case (w_comp)
      2'd1:    w_sel_data = bus.src_data[DATA_W +: DATA_W];
      2'd2:    w_sel_data = bus.src_data[2*DATA_W +: DATA_W];
      default: w_sel_data = bus.src_data[0 +: DATA_W];
    endcase
    w_sel_last = bus.src_last[w_comp];

    // Grant moves only on the transfer that closes the component's last block.
    if (w_xfer && w_sel_last) begin
      if (3'(r_blk_cnt + 3'd1) == w_blk_lim) begin
        w_blk_cnt_nxt = 3'd0;
        w_mcu_done    = (r_state == ST_CR) || ((r_state == ST_Y) && c_gray);
        if (w_mcu_done) begin
          w_mcu_cnt_nxt = w_mcu_inc;
          if (w_mcu_inc == r_mcu_total) begin
            w_state_nxt = ST_DRAIN;
            w_eof       = 1'b1;
          end else begin
            w_state_nxt = ST_Y;
          end
        end else begin
          w_state_nxt = (r_state == ST_Y) ? ST_CB : ST_CR;
        end
      end else begin
        w_blk_cnt_nxt = 3'(r_blk_cnt + 3'd1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt   <= 3'd0;
      r_mcu_cnt   <= '0;
      r_mcu_total <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_comp  <= 2'd0;
      r_out_last  <= 1'b0;
      r_out_eof   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_blk_cnt <= w_blk_cnt_nxt;
      r_mcu_cnt <= w_mcu_cnt_nxt;
      r_done    <= w_done_nxt;
      if (w_start_acc) begin
        r_mcu_total <= mcu_total;
        r_busy      <= 1'b1;
      end else if (w_done_nxt) begin
        r_busy <= 1'b0;
      end
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_comp  <= w_comp;
        r_out_last  <= w_sel_last;
        r_out_eof   <= w_eof;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.src_ready = w_src_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_comp  = r_out_comp;
  assign bus.out_last  = r_out_last;
  assign bus.out_eof   = r_out_eof;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule
`default_nettype wire

// File: tb/tb_huffman_mcu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_huffman_mcu_arbiter
//  Description : Randomized bench for huffman_mcu_arbiter. A frame is first
//                expanded into the list of beats in MCU interleave order;
//                the three source agents feed their own share of that list
//                and every cycle the grant, output register and status are
//                compared against what the list says must be happening.
//                Two instances: 4:2:0 colour and grayscale.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_huffman_mcu_arbiter;
  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct packed {
    logic [1:0]    comp;
    logic [DW-1:0] data;
    logic          last;
    logic          eof;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          sel;      // 0: colour instance active, 1: grayscale
  logic          start_t;
  logic [CW-1:0] total_t;
  logic [2:0]    valid_t, last_t;
  logic [3*DW-1:0] data_t;
  logic          ready_t;

  huffman_mcu_arbiter_if #(.DATA_W(DW)) bus_c ();
  huffman_mcu_arbiter_if #(.DATA_W(DW)) bus_g ();
  logic busy_c, done_c, busy_g, done_g;

  assign bus_c.src_valid = sel ? 3'b000 : valid_t;
  assign bus_g.src_valid = sel ? valid_t : 3'b000;
  assign bus_c.src_data  = data_t;
  assign bus_g.src_data  = data_t;
  assign bus_c.src_last  = last_t;
  assign bus_g.src_last  = last_t;
  assign bus_c.out_ready = sel ? 1'b1 : ready_t;
  assign bus_g.out_ready = sel ? ready_t : 1'b1;

  huffman_mcu_arbiter #(.DATA_W(DW), .Y_PER_MCU(4), .C_PER_MCU(1), .MCU_CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start_t && !sel), .mcu_total(total_t),
    .bus(bus_c), .busy(busy_c), .done(done_c));

  huffman_mcu_arbiter #(.DATA_W(DW), .Y_PER_MCU(4), .C_PER_MCU(0), .MCU_CNT_W(CW)) dut_g (
    .clk(clk), .rst_n(rst_n), .start(start_t && sel), .mcu_total(total_t),
    .bus(bus_g), .busy(busy_g), .done(done_g));

  logic [2:0]    m_ready;
  logic          m_ovalid, m_olast, m_oeof, m_busy, m_done;
  logic [DW-1:0] m_odata;
  logic [1:0]    m_ocomp;
  assign m_ready  = sel ? bus_g.src_ready : bus_c.src_ready;
  assign m_ovalid = sel ? bus_g.out_valid : bus_c.out_valid;
  assign m_odata  = sel ? bus_g.out_data  : bus_c.out_data;
  assign m_ocomp  = sel ? bus_g.out_comp  : bus_c.out_comp;
  assign m_olast  = sel ? bus_g.out_last  : bus_c.out_last;
  assign m_oeof   = sel ? bus_g.out_eof   : bus_c.out_eof;
  assign m_busy   = sel ? busy_g : busy_c;
  assign m_done   = sel ? done_g : done_c;

  int    n_checks = 0;
  int    n_fail = 0;
  beat_t exp_q[$];   // expected output order for the current frame
  beat_t obs_q[$];   // beats actually accepted downstream
  bit    any_cbcr_ready;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expand a frame into beats in interleave order. blen=0 picks 1..4 beats per block.
  task automatic build_frame(input int mcus, input int cpm, input int blen);
    beat_t b;
    int    len;
    int    nblk;
    exp_q.delete();
    obs_q.delete();
    for (int m = 0; m < mcus; m++) begin
      for (int c = 0; c < 3; c++) begin
        nblk = (c == 0) ? 4 : cpm;
        for (int k = 0; k < nblk; k++) begin
          len = (blen == 0) ? int'($urandom_range(1, 4)) : blen;
          for (int j = 0; j < len; j++) begin
            b.comp = 2'(c);
            b.data = $urandom;
            b.last = (j == len - 1);
            b.eof  = 1'b0;
            exp_q.push_back(b);
          end
        end
      end
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].eof = 1'b1;
  endtask

  function automatic int next_of(input int c, input int from);
    for (int i = from; i < exp_q.size(); i++)
      if (int'(exp_q[i].comp) == c) return i;
    return exp_q.size();
  endfunction

  task automatic check_reset_zero(input string nm);
    chk({nm, "_src_ready"}, 64'(m_ready), 64'd0);
    chk({nm, "_out_valid"}, 64'(m_ovalid), 64'd0);
    chk({nm, "_out_regs"}, 64'({m_ocomp, m_odata, m_olast, m_oeof}), 64'd0);
    chk({nm, "_busy_done"}, 64'({m_busy, m_done}), 64'd0);
  endtask

  // rmode: 0 ready high, 1 toggling, 2 random. abort_cb resets mid-Cb block.
  task automatic run_frame(input int mcus, input int rmode, input bit allvalid,
                           input bit noise, input bit abort_cb,
                           output int cycles, output bit aborted);
    int         sp[3];
    int         src_idx, out_idx, bound, sz;
    logic [2:0] exp_ready;
    bit         exp_ovalid;
    beat_t      cur;
    sz      = exp_q.size();
    bound   = sz * 10 + 50;
    src_idx = 0;
    out_idx = 0;
    cycles  = 0;
    aborted = 1'b0;
    for (int c = 0; c < 3; c++) sp[c] = next_of(c, 0);

    @(negedge clk);
    start_t = 1'b1; total_t = CW'(mcus); valid_t = 3'b000; ready_t = 1'b1;

    while (cycles < bound && out_idx < sz) begin
      @(negedge clk);
      if (abort_cb && src_idx > 0 && exp_q[src_idx-1].comp == 2'd1 && !exp_q[src_idx-1].last) begin
        rst_n = 1'b0;
        #1;
        check_reset_zero("midframe_reset");
        aborted = 1'b1;
        start_t = 1'b0; valid_t = 3'b000;
        return;
      end
      start_t = noise && ($urandom_range(0, 15) == 0);
      total_t = CW'($urandom);
      case (rmode)
        0:       ready_t = 1'b1;
        1:       ready_t = (cycles % 2 == 0);
        default: ready_t = ($urandom_range(0, 2) != 0);
      endcase
      for (int c = 0; c < 3; c++) begin
        if (sp[c] < sz) begin
          valid_t[c] = allvalid || ($urandom_range(0, 3) != 0);
          data_t[c*DW +: DW] = valid_t[c] ? exp_q[sp[c]].data : DW'($urandom);
          last_t[c] = valid_t[c] ? exp_q[sp[c]].last : 1'($urandom);
        end else begin
          valid_t[c] = 1'b0;
          data_t[c*DW +: DW] = DW'($urandom);
          last_t[c] = 1'($urandom);
        end
      end
      #1;
      // Model: one beat may sit in the output register; sources queue behind it.
      exp_ovalid = (src_idx > out_idx);
      exp_ready  = 3'b000;
      if (src_idx < sz && (!exp_ovalid || ready_t))
        exp_ready = 3'b001 << exp_q[src_idx].comp;
      if (m_ready[2:1] != 2'b00) any_cbcr_ready = 1'b1;
      chk("src_ready", 64'(m_ready), 64'(exp_ready));
      chk("out_valid", 64'(m_ovalid), 64'(exp_ovalid));
      if (exp_ovalid) begin
        cur = exp_q[out_idx];
        chk("out_beat", 64'({m_ocomp, m_odata, m_olast, m_oeof}), 64'(cur));
      end
      chk("busy_in_frame", 64'({m_busy, m_done}), 64'b10);
      if (m_ovalid && ready_t) obs_q.push_back({m_ocomp, m_odata, m_olast, m_oeof});
      for (int c = 0; c < 3; c++)
        if (valid_t[c] && m_ready[c]) sp[c] = next_of(c, sp[c] + 1);
      if (exp_ready != 3'b000 && (valid_t & exp_ready) != 3'b000) src_idx++;
      if (exp_ovalid && ready_t) out_idx++;
      cycles++;
    end
    chk("frame_complete", 64'(out_idx), 64'(sz));

    // Drain: register empties, then done one cycle later with busy dropping.
    @(negedge clk);
    valid_t = 3'b000; start_t = 1'b0; ready_t = 1'($urandom);
    #1;
    chk("drain_wait", 64'({m_ovalid, m_busy, m_done}), 64'b010);
    @(negedge clk); #1;
    chk("done_pulse", 64'({m_done, m_ready}), 64'b1000);
    @(negedge clk); #1;
    chk("done_end", 64'({m_busy, m_done}), 64'b00);
  endtask

  int cyc;
  bit ab;
  int n_eof, n_last, seen, n_done;

  initial begin
    sel = 1'b0; start_t = 1'b0; total_t = '0; valid_t = '0; last_t = '0;
    data_t = '0; ready_t = 1'b1; any_cbcr_ready = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    check_reset_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // T1: 4:2:0, two MCUs, 3-beat blocks, full throughput
    build_frame(2, 1, 3);
    run_frame(2, 0, 1'b1, 1'b0, 1'b0, cyc, ab);
    n_eof = 0; n_last = 0;
    foreach (obs_q[i]) begin
      n_eof  += int'(obs_q[i].eof);
      n_last += int'(obs_q[i].last);
    end
    chk("t1_beats", 64'(obs_q.size()), 64'd36);
    chk("t1_cycles", 64'(cyc), 64'd37);
    chk("t1_eof_count", 64'(n_eof), 64'd1);
    chk("t1_last_count", 64'(n_last), 64'd12);
    if (obs_q.size() == 36) begin
      chk("t1_eof_beat36", 64'(obs_q[35].eof), 64'd1);
      chk("t1_comp_b13", 64'(obs_q[12].comp), 64'd1);
      chk("t1_comp_b16", 64'(obs_q[15].comp), 64'd2);
      chk("t1_comp_b19", 64'(obs_q[18].comp), 64'd0);
      chk("t1_last_b3", 64'({obs_q[1].last, obs_q[2].last}), 64'b01);
    end

    // T2: all sources valid, out_ready toggling
    build_frame(3, 1, 0);
    run_frame(3, 1, 1'b1, 1'b0, 1'b0, cyc, ab);

    // T3: grayscale, three MCUs of 1-beat blocks
    sel = 1'b1;
    any_cbcr_ready = 1'b0;
    build_frame(3, 0, 1);
    run_frame(3, 0, 1'b1, 1'b0, 1'b0, cyc, ab);
    chk("t3_beats", 64'(obs_q.size()), 64'd12);
    if (obs_q.size() == 12) chk("t3_eof_beat12", 64'(obs_q[11].eof), 64'd1);
    chk("t3_no_cbcr_ready", 64'(any_cbcr_ready), 64'd0);
    sel = 1'b0;

    // T4: empty frame
    @(negedge clk);
    start_t = 1'b1; total_t = '0; valid_t = 3'b111; ready_t = 1'b1;
    seen = -1; n_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start_t = 1'b0;
      #1;
      chk("t4_no_grant", 64'({m_ready, m_ovalid}), 64'd0);
      if (m_done) begin
        n_done++;
        if (seen < 0) seen = i;
      end
    end
    chk("t4_done_cycle", 64'(seen), 64'd1);
    chk("t4_done_width", 64'(n_done), 64'd1);
    chk("t4_busy_after", 64'(m_busy), 64'd0);
    valid_t = 3'b000;

    // T5: start noise mid-frame, then reset inside a Cb block, then a fresh frame
    build_frame(3, 1, 3);
    run_frame(3, 2, 1'b0, 1'b1, 1'b0, cyc, ab);
    build_frame(4, 1, 3);
    run_frame(4, 2, 1'b0, 1'b0, 1'b1, cyc, ab);
    chk("t5_aborted_in_cb", 64'(ab), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    build_frame(1, 1, 2);
    run_frame(1, 0, 1'b0, 1'b0, 1'b0, cyc, ab);

    // Randomized frames on both instances
    for (int r = 0; r < 8; r++) begin
      int mc;
      sel = 1'($urandom);
      mc  = int'($urandom_range(1, 4));
      build_frame(mc, sel ? 0 : 1, 0);
      run_frame(mc, int'($urandom_range(0, 2)), 1'($urandom), 1'b1, 1'b0, cyc, ab);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
